// File: rtl/pg_pkg.sv
// pg_pkg
//   Shared definitions for the generate/propagate pre-processing stage.
//   - pg_state_e : skid-buffer occupancy (EMPTY / ONE / FULL), 2-bit encoding.
//   - PG_WIDTH_DEF: default operand width.
//   - pg_word_t  : one buffered g/p word at the default width.
//                  pg_gen_stage declares the same layout sized by its WIDTH parameter.
package pg_pkg;

  localparam int PG_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pg_state_e;

  typedef struct packed {
    logic [PG_WIDTH_DEF-1:0] g;
    logic [PG_WIDTH_DEF-1:0] p;
    logic                    cin;
  } pg_word_t;

endpackage

// File: rtl/pg_cell.sv
// pg_cell
//   Single-bit generate/propagate cell. This block is purely combinational.
//   Ports:
//     a_i : operand A bit
//     b_i : effective operand B bit (already inverted for subtract)
//     g_o : generate  = a & b
//     p_o : propagate = a ^ b
module pg_cell (
  input  logic a_i,
  input  logic b_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;

endmodule

// File: rtl/pg_gen_stage.sv
// pg_gen_stage
//   Registered generate/propagate stage feeding the prefix-tree dot cells.
//   Operand pairs are accepted under valid/ready. The stage forms per-bit g/p
//   and folds carry-in into g[0]. Results are presented from a 2-entry skid
//   buffer (main reg M, skid reg S), which sustains 1 op/clk. in_ready is a
//   register, so there is no combinational path from out_ready to in_ready.
//
//   Optional feature macro: ADDSUB_EN
//     defined   -> 'sub' port present; sub=1 selects b_eff=~b and cin_eff=1.
//     undefined -> no 'sub' port; b_eff=b and cin_eff=cin.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. A producer holds its data stable while valid=1 and ready=0.
//   in_valid is ignored while in_ready=0.
//
//   Ports:
//     clk, rst_n          : clock (rising edge), synchronous active-low reset
//     in_valid / in_ready : upstream handshake (in_ready registered, 0 in reset)
//     a, b, cin, [sub]    : operands, carry-in, optional subtract request
//     out_valid/out_ready : downstream handshake toward the prefix tree
//     g, p, cin_o         : generate (bit 0 folded), propagate, effective carry-in
//     dbg_state           : current buffer occupancy state
module pg_gen_stage
  import pg_pkg::*;
#(
  parameter int WIDTH = PG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p,
  output logic             cin_o,
  output pg_state_e        dbg_state
);

  // Same layout as pg_pkg::pg_word_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             cin;
  } stage_word_t;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] g_raw;
  logic [WIDTH-1:0] p_raw;
  stage_word_t      new_word;

  pg_state_e   state_q, state_d;
  stage_word_t m_q, m_d;
  stage_word_t s_q, s_d;
  logic        in_ready_q;
  logic        in_fire;
  logic        out_fire;

`ifdef ADDSUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;   // subtract forces carry-in to 1
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    pg_cell u_cell (
      .a_i (a[i]),
      .b_i (b_eff[i]),
      .g_o (g_raw[i]),
      .p_o (p_raw[i])
    );
  end

  // Carry-in is absorbed into g[0], so the tree sees bit 0 as a plain generate.
  // p[0] stays unfolded because sum bit 0 is p[0] ^ cin_o.
  assign new_word.g   = {g_raw[WIDTH-1:1], g_raw[0] | (p_raw[0] & cin_eff)};
  assign new_word.p   = p_raw;
  assign new_word.cin = cin_eff;

  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = new_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_d = new_word;
        end else if (in_fire) begin
          s_d     = new_word;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign g         = m_q.g;
  assign p         = m_q.p;
  assign cin_o     = m_q.cin;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pg_gen_stage.sv
// tb_pg_gen_stage
//   Directed bench for pg_gen_stage (WIDTH=32). Expected values are
//   hand-computed constants. Inputs change 1 time unit after a rising edge,
//   and outputs are checked at that same point.
module tb_pg_gen_stage;
  import pg_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
`ifdef ADDSUB_EN
  logic          sub;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic          cin_o;
  pg_state_e     dbg_state;

  int errors = 0;
  int checks = 0;

  pg_gen_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDSUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g         (g),
    .p         (p),
    .cin_o     (cin_o),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] eg, input logic [W-1:0] ep,
                         input logic ec);
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    chk({tag, "_g"}, g, eg);
    chk({tag, "_p"}, p, ep);
    chk({tag, "_cin"}, W'(cin_o), W'(ec));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 32'h1234_5678;
    b         = 32'h0F0F_0F0F;
    cin       = 1'b1;
    out_ready = 1'b0;
`ifdef ADDSUB_EN
    sub       = 1'b0;
`endif

    // reset held 3 clocks with in_valid=1
    repeat (3) step();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_g", g, '0);
    chk("rst_p", p, '0);
    chk("rst_cin_o", W'(cin_o), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));

    // release: in_ready was 0 at this edge, so the pending in_valid is ignored
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", W'(in_ready), W'(1));
    chk("rel_out_valid", W'(out_valid), W'(0));
    in_valid = 1'b0;
    step();
    chk("rel_still_empty", W'(out_valid), W'(0));

    // single add, 1-clk latency
    out_ready = 1'b1;
    drive(32'h0000_00F0, 32'h0000_0F0F, 1'b1);
    step();
    in_valid = 1'b0;
    chk_out("add1", 32'h0000_0001, 32'h0000_0FFF, 1'b1);
    step();
    chk("add1_drained", W'(out_valid), W'(0));

    // add with cin=0, bit 0 generates on its own
    drive(32'h0000_000F, 32'h0000_0003, 1'b0);
    step();
    in_valid = 1'b0;
    chk_out("add2", 32'h0000_0003, 32'h0000_000C, 1'b0);
    step();

`ifdef ADDSUB_EN
    // subtract: b_eff = ~3, cin forced to 1 even though cin input is 0
    sub = 1'b1;
    drive(32'h0000_0005, 32'h0000_0003, 1'b0);
    step();
    in_valid = 1'b0;
    sub      = 1'b0;
    chk_out("sub1", 32'h0000_0005, 32'hFFFF_FFF9, 1'b1);
    step();
`endif

    // backpressure: ops 1..4 with out_ready=0
    out_ready = 1'b0;
    drive(32'h0000_1111, 32'h0000_0101, 1'b0);              // op1
    step();
    chk("bp_one_in_ready", W'(in_ready), W'(1));
    chk_out("bp_op1_a", 32'h0000_0101, 32'h0000_1010, 1'b0);
    drive(32'hAAAA_0000, 32'h5555_0000, 1'b1);              // op2
    step();
    chk("bp_full_in_ready", W'(in_ready), W'(0));
    chk("bp_full_state", W'(dbg_state), W'(FULL));
    chk_out("bp_op1_b", 32'h0000_0101, 32'h0000_1010, 1'b0);
    drive(32'h8000_0001, 32'h8000_0000, 1'b1);              // op3 (held, ignored)
    step();
    chk("bp_hold_in_ready", W'(in_ready), W'(0));
    chk_out("bp_op1_c", 32'h0000_0101, 32'h0000_1010, 1'b0);
    step();
    chk_out("bp_op1_d", 32'h0000_0101, 32'h0000_1010, 1'b0);
    out_ready = 1'b1;
    step();                                                 // op1 out, S->M
    chk("bp_drain_in_ready", W'(in_ready), W'(1));
    chk_out("bp_op2", 32'h0000_0000, 32'hFFFF_0000, 1'b1);
    step();                                                 // op2 out, op3 in
    chk_out("bp_op3", 32'h8000_0001, 32'h0000_0001, 1'b1);
    drive(32'h0F0F_0F0E, 32'h00FF_00FF, 1'b0);              // op4
    step();
    in_valid = 1'b0;
    chk_out("bp_op4", 32'h000F_000E, 32'h0FF0_0FF1, 1'b0);
    step();
    chk("bp_empty", W'(out_valid), W'(0));

    // throughput: 100 back-to-back ops, b=0, cin=1 -> p=a, g=a&1
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      drive(W'(i), 32'h0, 1'b1);
      step();
      chk("tp_in_ready", W'(in_ready), W'(1));
      chk("tp_out_valid", W'(out_valid), W'(1));
      chk("tp_p", p, W'(i));
      chk("tp_g", g, W'(i & 1));
    end
    in_valid = 1'b0;
    step();
    chk("tp_empty", W'(out_valid), W'(0));

    // reset while FULL drops both buffered ops
    out_ready = 1'b0;
    drive(32'h0000_00AA, 32'h0000_0055, 1'b0);
    step();
    drive(32'h0000_0F00, 32'h0000_00F0, 1'b1);
    step();
    chk("mr_full_in_ready", W'(in_ready), W'(0));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("mr_out_valid", W'(out_valid), W'(0));
    chk("mr_g", g, '0);
    chk("mr_p", p, '0);
    chk("mr_cin_o", W'(cin_o), W'(0));
    chk("mr_in_ready", W'(in_ready), W'(0));
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mr_rel_in_ready", W'(in_ready), W'(1));
    chk("mr_rel_out_valid", W'(out_valid), W'(0));
    step();
    chk("mr_no_emit", W'(out_valid), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
